ibus_timer: RTL and testbench
=============================

IBUS_TIMER -- requirements
Module: ibus_timer

Interface
REQ-001 Parameter: BASE_ADR, 18'h3F000, word address ([19:2]) of the register block; bits [4:2] of BASE_ADR SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ibus_ren  input  1  read strobe from the bus master, one cycle per access.
REQ-005 ibus_radr  input  18 ([19:2])  read word address.
REQ-006 ibus32_rdata  output  16  read data, registered.
REQ-007 ibus_wen  input  1  write strobe, one cycle per access.
REQ-008 ibus_wadr  input  18 ([19:2])  write word address.
REQ-009 ibus32_wdata  input  16  write data, valid while ibus_wen=1.
REQ-010 interrupt_0  output  1  level interrupt to the CPU interrupter, registered.

Function
REQ-011 Select: an access SHALL hit when adr[19:5]==BASE_ADR[19:5]; offset = adr[4:2].
REQ-012 Register map by offset: 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 COUNT, 4 STATUS; offsets 5-7 are unmapped.
REQ-013 CTRL bits: [0] EN, [1] AUTO (auto-reload), [2] IEN (interrupt enable); bits [15:3] SHALL read 0 and ignore writes.
REQ-014 PRESCALE, COMPARE, COUNT: 16-bit read/write.
REQ-015 STATUS bit [0] MATCH: read; write 1 clears, write 0 no effect; bits [15:1] read 0.
REQ-016 Read latency: ibus32_rdata SHALL present the addressed register one cycle after ibus_ren=1 with a hit.
REQ-017 ibus32_rdata SHALL be 16'h0000 in any cycle not following a hit read, and after reads of unmapped offsets.
REQ-018 Writes to unmapped offsets or non-hit addresses SHALL be ignored.
REQ-019 Read and write to the same register in the same cycle: read SHALL return the pre-write value.
REQ-020 Prescaler: internal 16-bit pre_cnt; while EN=1, pre_cnt increments each cycle; when pre_cnt==PRESCALE a tick is generated and pre_cnt returns to 0 on the next edge.
REQ-021 PRESCALE=0 SHALL give a tick every cycle while EN=1.
REQ-022 While EN=0, pre_cnt SHALL be held at 0 and no ticks occur; COUNT holds.
REQ-023 On tick with COUNT!=COMPARE: COUNT<=COUNT+1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
REQ-024 On tick with COUNT==COMPARE: MATCH<=1; if AUTO=1 COUNT<=0 and EN stays 1; if AUTO=0 COUNT holds and EN<=0 (one-shot).
REQ-025 CPU write to COUNT in a tick cycle: the written value SHALL win and pre_cnt SHALL reset to 0.
REQ-026 Write to PRESCALE SHALL reset pre_cnt to 0.
REQ-027 CPU write to CTRL in the cycle a one-shot match clears EN: the written value SHALL win.
REQ-028 Match set and STATUS write-1-clear in the same cycle: set SHALL win (MATCH stays 1).
REQ-029 interrupt_0 SHALL equal registered (MATCH & IEN), i.e. one cycle after MATCH or IEN changes.
REQ-030 State: counter runs IDLE (EN=0) -> RUN (EN=1) -> on match RUN (AUTO=1) or IDLE (AUTO=0); CPU writes to CTRL move between states directly.

Reset
REQ-031 With rst_n=0 at a clock edge: CTRL=0, PRESCALE=0, COMPARE=16'hFFFF, COUNT=0, MATCH=0, pre_cnt=0, ibus32_rdata=0, interrupt_0=0.
REQ-032 Reset mid-count SHALL abandon all state; pending read data SHALL NOT appear after reset.

Verification
REQ-033 Write PRESCALE=3, COMPARE=2, CTRL=3'b111 -> ticks every 4 cycles; MATCH at 3rd tick (cycle 12 after EN), COUNT back to 0, interrupt_0=1 one cycle later.
REQ-034 AUTO=0, PRESCALE=0, COMPARE=5 -> COUNT stops at 5, CTRL reads 3'b100, MATCH=1; write STATUS=1 -> MATCH=0, interrupt_0 falls next cycle.
REQ-035 Read each offset 0-7 at BASE_ADR after reset -> 0,0,FFFF,0,0,0,0,0 one cycle after each ibus_ren; read at BASE_ADR+8 -> 0000.
REQ-036 COUNT=16'hFFFF, COMPARE=16'h0010, PRESCALE=0, EN=1 -> next tick COUNT=0000, MATCH stays 0.
REQ-037 Same-cycle match and STATUS clear -> MATCH=1; same-cycle tick and COUNT write 16'h1234 -> COUNT reads 1234.
REQ-038 Drive rst_n=0 for one edge mid-run with read outstanding -> all outputs 0 next cycle, COUNT reads 0.

Source files
------------

// File: rtl/ibus_timer.sv
// Bus-mapped 16-bit timer: prescaler, compare/auto-reload, sticky match flag
// and a level interrupt, accessed over a single-cycle read/write word bus.
module ibus_timer #(
    parameter logic [17:0] BASE_ADR = 18'h3F000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ibus_ren,
    input  logic [17:0] ibus_radr,
    output logic [15:0] ibus32_rdata,
    input  logic        ibus_wen,
    input  logic [17:0] ibus_wadr,
    input  logic [15:0] ibus32_wdata,
    output logic        interrupt_0
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRE    = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_CNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    logic        en;
    logic        auto_rl;
    logic        ien;
    logic [15:0] prescale;
    logic [15:0] compare;
    logic [15:0] count;
    logic [15:0] pre_cnt;
    logic        match;

    logic        r_hit;
    logic        w_hit;
    logic [2:0]  r_off;
    logic [2:0]  w_off;
    logic        tick;
    logic        hit_cmp;
    logic        wr_ctrl;
    logic        wr_pre;
    logic        wr_cmp;
    logic        wr_cnt;
    logic        wr_stat;
    logic [15:0] rd_mux;

    assign r_hit = ibus_ren && (ibus_radr[17:3] == BASE_ADR[17:3]);
    assign w_hit = ibus_wen && (ibus_wadr[17:3] == BASE_ADR[17:3]);
    assign r_off = ibus_radr[2:0];
    assign w_off = ibus_wadr[2:0];

    assign tick    = en && (pre_cnt == prescale);
    assign hit_cmp = tick && (count == compare);

    assign wr_ctrl = w_hit && (w_off == OFF_CTRL);
    assign wr_pre  = w_hit && (w_off == OFF_PRE);
    assign wr_cmp  = w_hit && (w_off == OFF_CMP);
    assign wr_cnt  = w_hit && (w_off == OFF_CNT);
    assign wr_stat = w_hit && (w_off == OFF_STATUS);

    // Mux sees current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = 16'h0000;
        if (r_hit) begin
            case (r_off)
                OFF_CTRL:   rd_mux = {13'd0, ien, auto_rl, en};
                OFF_PRE:    rd_mux = prescale;
                OFF_CMP:    rd_mux = compare;
                OFF_CNT:    rd_mux = count;
                OFF_STATUS: rd_mux = {15'd0, match};
                default:    rd_mux = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en           <= 1'b0;
            auto_rl      <= 1'b0;
            ien          <= 1'b0;
            prescale     <= 16'h0000;
            compare      <= 16'hFFFF;
            count        <= 16'h0000;
            pre_cnt      <= 16'h0000;
            match        <= 1'b0;
            ibus32_rdata <= 16'h0000;
            interrupt_0  <= 1'b0;
        end else begin
            if (!en || tick) begin
                pre_cnt <= 16'h0000;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end

            if (hit_cmp) begin
                match <= 1'b1;
                if (auto_rl) begin
                    count <= 16'h0000;
                end else begin
                    en <= 1'b0;
                end
            end else if (tick) begin
                count <= count + 16'd1;
            end

            // CPU writes override the timer's own updates.
            if (wr_ctrl) begin
                en      <= ibus32_wdata[0];
                auto_rl <= ibus32_wdata[1];
                ien     <= ibus32_wdata[2];
            end
            if (wr_pre) begin
                prescale <= ibus32_wdata;
                pre_cnt  <= 16'h0000;
            end
            if (wr_cmp) begin
                compare <= ibus32_wdata;
            end
            if (wr_cnt) begin
                count   <= ibus32_wdata;
                pre_cnt <= 16'h0000;
            end
            if (wr_stat && ibus32_wdata[0] && !hit_cmp) begin
                match <= 1'b0;
            end

            ibus32_rdata <= rd_mux;
            interrupt_0  <= match & ien;
        end
    end

endmodule

// File: tb/tb_ibus_timer.sv
// Randomised and directed checks of ibus_timer against a cycle model
// built from the register-map rules.
module tb_ibus_timer;

    localparam logic [17:0] BASE = 18'h3F000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_ren;
    logic [17:0] ibus_radr;
    logic [15:0] ibus32_rdata;
    logic        ibus_wen;
    logic [17:0] ibus_wadr;
    logic [15:0] ibus32_wdata;
    logic        interrupt_0;

    int checks = 0;
    int errors = 0;

    ibus_timer #(.BASE_ADR(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_ren     (ibus_ren),
        .ibus_radr    (ibus_radr),
        .ibus32_rdata (ibus32_rdata),
        .ibus_wen     (ibus_wen),
        .ibus_wadr    (ibus_wadr),
        .ibus32_wdata (ibus32_wdata),
        .interrupt_0  (interrupt_0)
    );

    always #5 clk = ~clk;

    // Model state: regs[0..4] = CTRL, PRESCALE, COMPARE, COUNT, STATUS
    int unsigned regs [5];
    int unsigned m_pc;
    int unsigned exp_rd;
    bit          exp_irq;
    bit          m_valid = 1'b0;

    function automatic bit is_hit(logic [17:0] a);
        return (a >> 3) == (BASE >> 3);
    endfunction

    always @(posedge clk) begin
        int unsigned rd_v;
        int unsigned off;
        bit tick;
        bit hm;
        if (!rst_n) begin
            regs[0] = 0; regs[1] = 0; regs[2] = 16'hFFFF;
            regs[3] = 0; regs[4] = 0;
            m_pc = 0; exp_rd = 0; exp_irq = 0;
            m_valid = 1'b1;
        end else begin
            rd_v = 0;
            if (ibus_ren && is_hit(ibus_radr)) begin
                off = ibus_radr % 8;
                if (off < 5) rd_v = regs[off];
            end
            exp_rd  = rd_v;
            exp_irq = (regs[4] == 1) && (regs[0] / 4 % 2 == 1);
            tick = (regs[0] % 2 == 1) && (m_pc == regs[1]);
            hm   = tick && (regs[3] == regs[2]);
            if (!tick && regs[0] % 2 == 1) m_pc = (m_pc + 1) % 65536;
            else m_pc = 0;
            if (hm) begin
                regs[4] = 1;
                if (regs[0] / 2 % 2 == 1) regs[3] = 0;
                else regs[0] = regs[0] - 1;
            end else if (tick) begin
                regs[3] = (regs[3] + 1) % 65536;
            end
            if (ibus_wen && is_hit(ibus_wadr)) begin
                off = ibus_wadr % 8;
                case (off)
                    0: regs[0] = ibus32_wdata % 8;
                    1: begin regs[1] = ibus32_wdata; m_pc = 0; end
                    2: regs[2] = ibus32_wdata;
                    3: begin regs[3] = ibus32_wdata; m_pc = 0; end
                    4: if (ibus32_wdata[0] && !hm) regs[4] = 0;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (ibus32_rdata !== 16'(exp_rd)) begin
                errors++;
                $display("FAIL rdata t=%0t got %h want %h",
                         $time, ibus32_rdata, 16'(exp_rd));
            end
            checks++;
            if (interrupt_0 !== exp_irq) begin
                errors++;
                $display("FAIL irq t=%0t got %b want %b",
                         $time, interrupt_0, exp_irq);
            end
        end
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(int off, logic [15:0] d);
        ibus_wen     = 1'b1;
        ibus_wadr    = BASE | 18'(off);
        ibus32_wdata = d;
        @(negedge clk);
        ibus_wen = 1'b0;
    endtask

    task automatic rd_adr(logic [17:0] a, output logic [15:0] d);
        ibus_ren  = 1'b1;
        ibus_radr = a;
        @(negedge clk);
        ibus_ren = 1'b0;
        d = ibus32_rdata;
    endtask

    task automatic rd(int off, output logic [15:0] d);
        rd_adr(BASE | 18'(off), d);
    endtask

    logic [15:0] v;
    logic [15:0] rst_vals [8];

    initial begin
        rst_n = 1'b0;
        ibus_ren = 1'b0; ibus_radr = '0;
        ibus_wen = 1'b0; ibus_wadr = '0; ibus32_wdata = '0;
        rst_vals = '{16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_irq", {15'd0, interrupt_0}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk($sformatf("reset_rd%0d", i), v, rst_vals[i]);
        end
        rd_adr(BASE + 18'd8, v);
        chk("miss_rd", v, 16'h0000);

        // prescaled auto-reload run
        wr(1, 16'd3);
        wr(2, 16'd2);
        wr(0, 16'h0007);
        repeat (12) @(negedge clk);
        chk("auto_irq_pre", {15'd0, interrupt_0}, 16'h0);
        @(negedge clk);
        chk("auto_irq", {15'd0, interrupt_0}, 16'h1);
        rd(4, v); chk("auto_match", v, 16'h0001);
        rd(3, v); chk("auto_count", v, 16'h0000);
        wr(0, 16'h0000);
        wr(4, 16'h0001);

        // one-shot
        wr(3, 16'h0000);
        wr(1, 16'h0000);
        wr(2, 16'd5);
        wr(0, 16'h0005);
        repeat (10) @(negedge clk);
        rd(3, v); chk("oneshot_count", v, 16'h0005);
        rd(0, v); chk("oneshot_ctrl", v, 16'h0004);
        rd(4, v); chk("oneshot_match", v, 16'h0001);
        chk("oneshot_irq", {15'd0, interrupt_0}, 16'h1);
        wr(4, 16'h0001);
        chk("clr_irq_lag", {15'd0, interrupt_0}, 16'h1);
        @(negedge clk);
        chk("clr_irq", {15'd0, interrupt_0}, 16'h0);

        // wrap without match
        wr(0, 16'h0000);
        wr(2, 16'h0010);
        wr(3, 16'hFFFF);
        wr(1, 16'h0000);
        wr(0, 16'h0001);
        rd(3, v); chk("wrap_pre", v, 16'hFFFF);
        rd(3, v); chk("wrap_cnt", v, 16'h0000);
        rd(4, v); chk("wrap_match", v, 16'h0000);

        // match and clear in same cycle
        wr(0, 16'h0000);
        wr(3, 16'h0000);
        wr(2, 16'd3);
        wr(0, 16'h0001);
        repeat (3) @(negedge clk);
        wr(4, 16'h0001);
        rd(4, v); chk("set_beats_clr", v, 16'h0001);

        // count write on a tick
        wr(2, 16'h8000);
        wr(0, 16'h0001);
        wr(3, 16'h1234);
        rd(3, v); chk("cnt_wr_tick", v, 16'h1234);

        // reset with read outstanding
        wr(0, 16'h0005);
        @(negedge clk);
        chk("pre_rst_irq", {15'd0, interrupt_0}, 16'h1);
        ibus_ren = 1'b1; ibus_radr = BASE | 18'd3; rst_n = 1'b0;
        @(negedge clk);
        ibus_ren = 1'b0; rst_n = 1'b1;
        chk("rst_rdata", ibus32_rdata, 16'h0000);
        chk("rst_irq", {15'd0, interrupt_0}, 16'h0);
        rd(3, v); chk("rst_count", v, 16'h0000);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            ibus_ren  = ($urandom % 3) == 0;
            ibus_radr = ($urandom % 6 == 0) ? 18'($urandom)
                                            : BASE | 18'($urandom % 8);
            ibus_wen  = ($urandom % 6) == 0;
            ibus_wadr = ($urandom % 10 == 0) ? 18'($urandom)
                                             : BASE | 18'($urandom % 8);
            case (ibus_wadr % 8)
                1: ibus32_wdata = 16'($urandom % 4);
                2: ibus32_wdata = 16'($urandom % 12);
                3: ibus32_wdata = ($urandom % 8 == 0) ? 16'hFFFF
                                                      : 16'($urandom % 8);
                default: ibus32_wdata = 16'($urandom);
            endcase
            rst_n = ($urandom % 700) != 0;
            @(negedge clk);
        end
        ibus_ren = 1'b0; ibus_wen = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
